// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: synchronise, debounce, then emit a clean level,
// one-cycle rise/fall pulses, sticky maskable edge flags and an aggregate irq.
module multi_edge_detector #(
    parameter int   CHANNELS        = 4,
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] signal_in,
    input  logic [CHANNELS-1:0] rise_en,
    input  logic [CHANNELS-1:0] fall_en,
    input  logic [CHANNELS-1:0] flag_clr,
    output logic [CHANNELS-1:0] level_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic [CHANNELS-1:0] rise_flag,
    output logic [CHANNELS-1:0] fall_flag,
    output logic                irq
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] sync;
    logic [CNT_W-1:0]    cnt_q  [CHANNELS];
    logic [CNT_W-1:0]    cnt_d  [CHANNELS];
    logic [CHANNELS-1:0] level_q, level_d;
    logic [CHANNELS-1:0] rise_pulse_q, rise_pulse_d;
    logic [CHANNELS-1:0] fall_pulse_q, fall_pulse_d;
    logic [CHANNELS-1:0] rise_flag_q, rise_flag_d;
    logic [CHANNELS-1:0] fall_flag_q, fall_flag_d;
    logic                irq_q;

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        level_d      = level_q;
        rise_pulse_d = '0;
        fall_pulse_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            cnt_d[c] = cnt_q[c];
            // Terminal compare comes before increment, so the counter never wraps.
            if (sync[c] == level_q[c]) begin
                cnt_d[c] = '0;
            end else if (cnt_q[c] == CNT_LAST) begin
                cnt_d[c]        = '0;
                level_d[c]      = sync[c];
                rise_pulse_d[c] = sync[c];
                fall_pulse_d[c] = ~sync[c];
            end else begin
                cnt_d[c] = cnt_q[c] + 1'b1;
            end
        end
        // A set on the same edge as a clear wins.
        rise_flag_d = (rise_pulse_d & rise_en) | (rise_flag_q & ~flag_clr);
        fall_flag_d = (fall_pulse_d & fall_en) | (fall_flag_q & ~flag_clr);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the per-channel arrays are real state, so each element is reset explicitly.
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= {CHANNELS{RESET_LEVEL}};
            end
            for (int c = 0; c < CHANNELS; c++) begin
                cnt_q[c] <= '0;
            end
            level_q      <= {CHANNELS{RESET_LEVEL}};
            rise_pulse_q <= '0;
            fall_pulse_q <= '0;
            rise_flag_q  <= '0;
            fall_flag_q  <= '0;
            irq_q        <= 1'b0;
        end else begin
            sync_q[0] <= signal_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            rise_pulse_q <= rise_pulse_d;
            fall_pulse_q <= fall_pulse_d;
            rise_flag_q  <= rise_flag_d;
            fall_flag_q  <= fall_flag_d;
            irq_q        <= |(rise_flag_q | fall_flag_q);
        end
    end

    assign level_out  = level_q;
    assign rise_pulse = rise_pulse_q;
    assign fall_pulse = fall_pulse_q;
    assign rise_flag  = rise_flag_q;
    assign fall_flag  = fall_flag_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Self-checking bench for multi_edge_detector: directed scenarios plus random
// stimulus checked every cycle against a window-based behavioural model.
module tb_multi_edge_detector;

    localparam int   CH   = 4;
    localparam int   SYNC = 2;
    localparam int   DEB  = 4;
    localparam logic RL   = 1'b0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CH-1:0] signal_in, rise_en, fall_en, flag_clr;
    logic [CH-1:0] level_out, rise_pulse, fall_pulse, rise_flag, fall_flag;
    logic          irq;

    int n_total = 0;
    int n_bad   = 0;

    // Model state: input history and the synchronised value each edge acted on.
    logic [CH-1:0] in_q[$];
    logic [CH-1:0] sh_q[$];
    logic [CH-1:0] m_level, m_rise, m_fall, m_rf, m_ff;
    logic          m_irq;

    multi_edge_detector #(
        .CHANNELS       (CH),
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .RESET_LEVEL    (RL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .signal_in (signal_in),
        .rise_en   (rise_en),
        .fall_en   (fall_en),
        .flag_clr  (flag_clr),
        .level_out (level_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .rise_flag (rise_flag),
        .fall_flag (fall_flag),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, total=%0d", n_total);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        in_q.delete();
        sh_q.delete();
        m_level = {CH{RL}};
        m_rise  = '0;
        m_fall  = '0;
        m_rf    = '0;
        m_ff    = '0;
        m_irq   = 1'b0;
    endtask

    // A level is accepted once the last DEB synchronised samples all disagree with it.
    task automatic model_edge();
        logic [CH-1:0] sp, tmp, nrise, nfall;
        bit all_diff;
        if (!rst_n) return;
        sp = (in_q.size() >= SYNC) ? in_q[in_q.size()-SYNC] : {CH{RL}};
        in_q.push_back(signal_in);
        sh_q.push_back(sp);
        if (in_q.size() > 32) void'(in_q.pop_front());
        if (sh_q.size() > 32) void'(sh_q.pop_front());
        m_irq = |(m_rf | m_ff);
        nrise = '0;
        nfall = '0;
        for (int c = 0; c < CH; c++) begin
            if (sh_q.size() >= DEB) begin
                all_diff = 1'b1;
                for (int j = 0; j < DEB; j++) begin
                    tmp = sh_q[sh_q.size()-1-j];
                    if (tmp[c] == m_level[c]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    if (m_level[c]) nfall[c] = 1'b1;
                    else            nrise[c] = 1'b1;
                end
            end
        end
        m_level = m_level ^ (nrise | nfall);
        m_rf    = (nrise & rise_en) | (m_rf & ~flag_clr);
        m_ff    = (nfall & fall_en) | (m_ff & ~flag_clr);
        m_rise  = nrise;
        m_fall  = nfall;
    endtask

    task automatic compare_all();
        check("level", 32'(level_out), 32'(m_level));
        check("rise_pulse", 32'(rise_pulse), 32'(m_rise));
        check("fall_pulse", 32'(fall_pulse), 32'(m_fall));
        check("rise_flag", 32'(rise_flag), 32'(m_rf));
        check("fall_flag", 32'(fall_flag), 32'(m_ff));
        check("irq", 32'(irq), 32'(m_irq));
    endtask

    // One clock: model updates on the rising edge, outputs compared on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int rcnt, fcnt;
        int hold [CH];
        bit pat [9] = '{1, 1, 1, 0, 1, 1, 1, 1, 1};

        signal_in = '0;
        rise_en   = '1;
        fall_en   = '1;
        flag_clr  = '0;
        rst_n     = 1'b0;
        model_reset();
        #1;
        check("reset_level", 32'(level_out), 32'({CH{RL}}));
        check("reset_flags", 32'({rise_flag, fall_flag}), 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();

        // Step on channel 0: level and pulse after edge 6, irq after edge 7.
        signal_in[0] = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step();
            if (i == 5) check("t1_level_e5", 32'(level_out[0]), 32'd0);
            if (i == 6) begin
                check("t1_level_e6", 32'(level_out[0]), 32'd1);
                check("t1_rpulse_e6", 32'(rise_pulse[0]), 32'd1);
                check("t1_irq_e6", 32'(irq), 32'd0);
            end
            if (i == 7) begin
                check("t1_rpulse_e7", 32'(rise_pulse[0]), 32'd0);
                check("t1_irq_e7", 32'(irq), 32'd1);
            end
        end

        // Bounce on channel 1: only the second burst is accepted, at edge 10.
        rcnt = 0;
        for (int i = 0; i < 14; i++) begin
            if (i < 9) signal_in[1] = pat[i];
            step();
            if (rise_pulse[1]) rcnt++;
            if (i == 9) check("t2_rpulse_e10", 32'(rise_pulse[1]), 32'd1);
        end
        check("t2_pulse_count", 32'(rcnt), 32'd1);

        flag_clr = '1;
        step();
        flag_clr = '0;
        step();
        check("clr_all_irq", 32'(irq), 32'd0);

        // Enables: only the falling edge of channel 2 may set a flag.
        rise_en = '0;
        fall_en = '1;
        rcnt = 0;
        fcnt = 0;
        signal_in[2] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) signal_in[2] = 1'b0;
            step();
            if (rise_pulse[2]) rcnt++;
            if (fall_pulse[2]) fcnt++;
        end
        check("t3_rise_count", 32'(rcnt), 32'd1);
        check("t3_fall_count", 32'(fcnt), 32'd1);
        check("t3_rise_flag", 32'(rise_flag[2]), 32'd0);
        check("t3_fall_flag", 32'(fall_flag[2]), 32'd1);
        check("t3_irq_set", 32'(irq), 32'd1);
        flag_clr[2] = 1'b1;
        step();
        flag_clr[2] = 1'b0;
        check("t3_fall_flag_clr", 32'(fall_flag[2]), 32'd0);
        check("t3_irq_lag", 32'(irq), 32'd1);
        step();
        check("t3_irq_clr", 32'(irq), 32'd0);

        // Set/clear collision on channel 3.
        rise_en = '1;
        signal_in[3] = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            if (i == 6) flag_clr[3] = 1'b1;
            step();
            if (i == 6) begin
                flag_clr[3] = 1'b0;
                check("t4_rflag_collide", 32'(rise_flag[3]), 32'd1);
                check("t4_rpulse", 32'(rise_pulse[3]), 32'd1);
            end
        end
        check("t4_irq", 32'(irq), 32'd1);

        // Reset mid-count on channel 0, input held high across reset.
        signal_in[0] = 1'b0;
        repeat (8) step();
        signal_in[0] = 1'b1;
        repeat (4) step();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t5_async_level", 32'(level_out), 32'({CH{RL}}));
        check("t5_async_flags", 32'({rise_flag, fall_flag}), 32'd0);
        check("t5_async_pulses", 32'({rise_pulse, fall_pulse}), 32'd0);
        check("t5_async_irq", 32'(irq), 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step();
            check("t5_rpulse", 32'(rise_pulse[0]), 32'(i == 6));
            check("t5_level", 32'(level_out[0]), 32'(i >= 6));
        end

        // Random stimulus on all channels with mixed hold lengths.
        for (int c = 0; c < CH; c++) hold[c] = 1 + c;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < CH; c++) begin
                if (hold[c] == 0) begin
                    signal_in[c] = ~signal_in[c];
                    hold[c] = int'($urandom_range(1, 9));
                end else begin
                    hold[c]--;
                end
                flag_clr[c] = ($urandom_range(0, 7) == 0);
            end
            if (n % 16 == 0) begin
                rise_en = CH'($urandom);
                fall_en = CH'($urandom);
            end
            if (n == 1500) begin
                rst_n = 1'b0;
                model_reset();
                step();
                step();
                rst_n = 1'b1;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/multi_edge_detector.md
# multi_edge_detector

Parametrised, multi-channel successor to the single-bit edge detector. Each channel synchronises an asynchronous input, debounces it with a per-channel stability counter, and produces a clean level, one-cycle rise/fall pulses and sticky, maskable edge flags with a clear interface. An aggregate interrupt output lets the reaction-timer control FSM service buttons and sensors without polling each channel.

## Interface
- `CHANNELS`, 4: number of independent input channels (≥1).
- `SYNC_STAGES`, 2: synchroniser depth in flops (≥2).
- `DEBOUNCE_CYCLES`, 16: consecutive cycles a new level must hold before it is accepted (≥1; 1 means no filtering beyond synchronisation).
- `RESET_LEVEL`, 0: value loaded into the synchroniser and the debounced level on reset (applies to all channels).

- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `signal_in`  in  CHANNELS  raw asynchronous inputs.
- `rise_en`  in  CHANNELS  per-channel enable for setting `rise_flag`.
- `fall_en`  in  CHANNELS  per-channel enable for setting `fall_flag`.
- `flag_clr`  in  CHANNELS  one-cycle clear of both sticky flags of the channel.
- `level_out`  out  CHANNELS  debounced level.
- `rise_pulse`  out  CHANNELS  one-cycle pulse on an accepted 0→1 transition.
- `fall_pulse`  out  CHANNELS  one-cycle pulse on an accepted 1→0 transition.
- `rise_flag`  out  CHANNELS  sticky, set by an enabled rising edge.
- `fall_flag`  out  CHANNELS  sticky, set by an enabled falling edge.
- `irq`  out  1  OR of all `rise_flag` and `fall_flag` bits, registered.

## Operation
- Reset (`rst_n` low, async): all synchroniser flops and `level_out` = `RESET_LEVEL`; debounce counters = 0; `rise_pulse`, `fall_pulse`, `rise_flag`, `fall_flag`, `irq` = 0.
- Synchroniser: per channel a `SYNC_STAGES`-deep shift register; `sync` = last stage. No logic between stages.
- Debounce counter, width `$clog2(DEBOUNCE_CYCLES)` (min 1), per channel, each edge:
  - `sync == level_out`: counter ← 0.
  - `sync != level_out` and counter == `DEBOUNCE_CYCLES-1`: `level_out` ← `sync`, counter ← 0.
  - otherwise: counter ← counter + 1. The counter never wraps; the terminal compare precedes increment.
- Any bounce (mismatch interrupted by one matching cycle) restarts the count from 0.
- Pulses: on the edge where `level_out` updates, `rise_pulse` (new level 1) or `fall_pulse` (new level 0) is registered high for exactly one cycle, coincident with the new `level_out` value. Rise and fall of the same channel never assert together.
- Flags: `rise_flag[i]` ← 1 when `level_out` updates 0→1 and `rise_en[i]`; likewise `fall_flag[i]` for 1→0 with `fall_en[i]`. `flag_clr[i]` clears both flags of channel i. Simultaneous set and clear: set wins (the flag is 1 the next cycle).
- Enables gate only flag setting; pulses and `level_out` are unaffected by `rise_en`/`fall_en`.
- Channels are fully independent; no shared counter or arbitration.

## Timing
- Input change settled before edge 1: `sync` changes after edge `SYNC_STAGES`; `level_out`, pulse and flag change after edge `SYNC_STAGES + DEBOUNCE_CYCLES`.
- `irq` follows flag state one cycle later (after edge `SYNC_STAGES + DEBOUNCE_CYCLES + 1`); it deasserts one cycle after the last flag clears.
- `flag_clr` sampled at edge n: flag is 0 after edge n; `irq` is 0 after edge n+1 if no other flag is set.
- Minimum accepted pulse width on `signal_in`: `DEBOUNCE_CYCLES` cycles; shorter glitches produce no output change.
- Reset asserted mid-count: counter and outputs return to reset values immediately; no pulse is emitted on reset release, even if `signal_in` differs from `RESET_LEVEL`. That difference is then debounced normally and yields one edge.

## Test plan
- Defaults except `DEBOUNCE_CYCLES`=4: channel 0 steps 0→1 before edge 1 -> `level_out[0]`=1 and `rise_pulse[0]`=1 for one cycle after edge 6; `irq`=1 after edge 7 with `rise_en[0]`=1.
- Bounce: channel 1 high for 3 cycles, low 1, high 5 -> exactly one `rise_pulse[1]`, 4 cycles after the second rise reaches `sync`; no pulse from the first burst.
- Flags: `rise_en`=0, `fall_en`=1; channel 2 toggles 0→1→0 with 10-cycle holds -> both pulses seen, only `fall_flag[2]`=1; `flag_clr[2]` pulse -> flag 0, `irq` 0 one cycle later.
- Set/clear collision: `flag_clr[3]` asserted on the same edge `rise_flag[3]` is set -> `rise_flag[3]` stays 1.
- Reset mid-operation: channel 0 at counter 2 of 4, deassert `rst_n` for 1 cycle -> all outputs 0 asynchronously; with the input held high, after release a single `rise_pulse[0]` follows 6 edges later.
- Independence: all 4 channels driven with different edge timings simultaneously -> each channel's outputs match the single-channel reference model cycle-for-cycle.
